bicubic_h_filter: RTL and testbench
===================================

Name: bicubic_h_filter

Overview:
- Downstream consumer of the four horizontal bicubic weight stages (tap weights for x0..x3).
- Applies the four Q1.8 weights to a 4-pixel horizontal window, per colour channel, and produces one rounded, clamped output pixel per valid input.
- Internal delay line aligns each pixel window with weights that arrive WGT_LAT cycles after it; 3-stage MAC pipeline follows.
- Sits between the line-buffer/window fetch and the vertical filter pass.

Parameters:
- DW, 8, bits per colour channel
- CH, 3, colour channels per pixel
- WW, 9, weight width (unsigned magnitude)
- FRAC, 8, weight fraction bits (1.0 = 256)
- WGT_LAT, 4, cycles from window presentation to matching weights on w0..w3; legal range 0..15

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pixel window valid this cycle
- in_last  in  1  last window of the output line, travels with data
- p0,p1,p2,p3  in  CH*DW each  taps x0..x3, channel 0 in LSBs
- w0,w1,w2,w3  in  WW each  tap weight magnitudes, valid WGT_LAT cycles after matching in_valid
- out_valid  out  1  output pixel valid
- out_last  out  1  aligned in_last
- out_pix  out  CH*DW  filtered pixel
- sat_cnt  out  16  clamp-event counter (feature only, else tied 0)

Behaviour:
- Reset: asynchronous. Clears all valid/last pipeline bits, out_valid=0, out_last=0, out_pix=0, sat_cnt=0. Data registers may also clear. Reset mid-operation drops all in-flight windows; nothing emerges after release.
- Weight sign: w0 and w3 are outer-tap magnitudes and are subtracted; w1 and w2 are added. Per channel c: acc = w1*p1 + w2*p2 - w0*p0 - w3*p3, signed, width DW+WW+3 (20 bits at defaults), with no overflow possible.
- Alignment: p0..p3, in_valid and in_last pass through a WGT_LAT-deep shift register. WGT_LAT=0 means no stage. Weights are sampled in the cycle where the delayed valid is high and are ignored otherwise.
- Pipeline after alignment:
  - S1: four products per channel, registered.
  - S2: (w1p1 + w2p2) and (w0p0 + w3p3), registered.
  - S3: difference, + 2^(FRAC-1), arithmetic shift right FRAC, clamp to [0, 2^DW-1], registered to out_pix.
- Latency: in_valid at cycle t gives out_valid at t+WGT_LAT+3. Throughput is 1 window/clk. There is no backpressure; bubbles pass through unchanged.
- out_pix holds its last value while out_valid=0. out_last is only meaningful with out_valid.
- Clamp: a negative result gives 0; a result above 2^DW-1 gives 2^DW-1. Each channel clamps independently.
- Simultaneous in_valid on consecutive cycles: each window uses its own aligned weights; there is no cross-window interaction.

Optional Feature:
- Macro: BICUBIC_HFILT_SATCNT_EN.
- Defined: sat_cnt increments by 1 for each out_valid beat in which any channel clamped (at most +1 per beat). It saturates at 16'hFFFF and clears only on reset.
- Undefined: no counter logic; sat_cnt tied to 0.

Decomposition:
- Shared package: FRAC, WW, the rounding constant, the accumulator-width function (DW+WW+3), and the clamp max derived from DW. These are shared with the vertical filter and the weight stages.
- One natural sub-module, bicubic_tap_mac: single-channel 3-stage MAC, round and clamp, exporting a per-channel clamp flag. Instantiated CH times.
- Delay line, valid/last pipe and sat counter live in the top.

Test Plan:
- Identity phase: w=(0,256,0,0), p1=(10,20,30), one in_valid at cycle 0 -> out_pix=(10,20,30) with out_valid exactly at cycle WGT_LAT+3, one beat only.
- Flat half-phase: w=(16,144,144,16), all taps 100 -> out 100 on every channel.
- Step edge: w=(16,144,144,16), p=(0,0,255,255) -> out 128 (32640+128>>8).
- Clamps, w=(16,144,144,16):
  - p=(255,0,0,255) -> 0.
  - p=(0,255,255,0) -> 255 (raw 287).
  - With feature: sat_cnt increments by 1 per clamped beat.
- Back-to-back burst: 8 consecutive windows with differing weights, in_last on the 8th -> 8 consecutive correct outputs, out_last only on the 8th. Repeat with one-cycle bubbles inserted and confirm the bubbles are preserved.
- Reset mid-burst: assert rst_n low while 3 windows are in flight -> outputs and sat_cnt go to 0 immediately; no out_valid after release until new input plus latency.

Source files
------------

// File: rtl/bicubic_h_filter_pkg.sv
// bicubic_h_filter_pkg
//   Constants and helpers shared by the horizontal/vertical bicubic filters
//   and the weight stages: weight format, rounding constant, accumulator
//   width and output clamp limit.
package bicubic_h_filter_pkg;

    localparam int FRAC = 8;                // weight fraction bits (1.0 = 256)
    localparam int WW   = 9;                // weight magnitude width
    localparam int RND  = 1 << (FRAC - 1);  // round-half-up constant at default FRAC

    // Rounding constant for an arbitrary fraction width.
    function automatic int rnd_const(input int frac);
        return 1 << (frac - 1);
    endfunction

    // Signed accumulator width for a 4-tap +,+,-,- MAC: product + 2 sum
    // bits + sign. Cannot overflow for any input.
    function automatic int acc_w(input int dw);
        return dw + WW + 3;
    endfunction

    // Largest representable output pixel value.
    function automatic int clamp_max(input int dw);
        return (1 << dw) - 1;
    endfunction

endpackage

// File: rtl/bicubic_tap_mac.sv
// bicubic_tap_mac
//   Single-channel 4-tap bicubic MAC: S1 products, S2 positive/negative
//   partial sums, S3 difference + round + shift + clamp into pix.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   en[2:0]       stage load enables (S1, S2, S3); stages hold otherwise
//   p0..p3        channel samples of taps x0..x3
//   w0..w3        tap weight magnitudes (w0, w3 subtracted)
//   pix           registered, clamped result
//   clamp         combinational: the result entering S3 needs clamping
module bicubic_tap_mac #(
    parameter int DW   = 8,
    parameter int WW   = bicubic_h_filter_pkg::WW,
    parameter int FRAC = bicubic_h_filter_pkg::FRAC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    en,
    input  logic [DW-1:0] p0,
    input  logic [DW-1:0] p1,
    input  logic [DW-1:0] p2,
    input  logic [DW-1:0] p3,
    input  logic [WW-1:0] w0,
    input  logic [WW-1:0] w1,
    input  logic [WW-1:0] w2,
    input  logic [WW-1:0] w3,
    output logic [DW-1:0] pix,
    output logic          clamp
);
    import bicubic_h_filter_pkg::*;

    localparam int PW = DW + WW;
    localparam int SW = PW + 1;
    localparam int AW = acc_w(DW);
    localparam logic signed [AW-1:0] RNDV = AW'(rnd_const(FRAC));
    localparam logic signed [AW-1:0] CMAX = AW'(clamp_max(DW));

    logic [PW-1:0] m0, m1, m2, m3;
    logic [SW-1:0] s_pos, s_neg;
    logic signed [AW-1:0] acc, shifted;
    logic          lo, hi;
    logic [DW-1:0] pix_n;

    // S1: products, weights only captured with the aligned window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= '0; m1 <= '0; m2 <= '0; m3 <= '0;
        end else if (en[0]) begin
            m0 <= PW'(w0) * PW'(p0);
            m1 <= PW'(w1) * PW'(p1);
            m2 <= PW'(w2) * PW'(p2);
            m3 <= PW'(w3) * PW'(p3);
        end
    end

    // S2: inner taps add, outer taps subtract later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_pos <= '0; s_neg <= '0;
        end else if (en[1]) begin
            s_pos <= SW'(m1) + SW'(m2);
            s_neg <= SW'(m0) + SW'(m3);
        end
    end

    // S3: zero-extended sums, so the difference is a true signed value;
    // >>> floors, giving round-half-up after adding RNDV.
    always_comb begin
        acc     = $signed(AW'(s_pos)) - $signed(AW'(s_neg));
        shifted = (acc + RNDV) >>> FRAC;
        lo      = shifted < 0;
        hi      = shifted > CMAX;
        pix_n   = shifted[DW-1:0];
        if (lo)      pix_n = '0;
        else if (hi) pix_n = '1;
    end

    assign clamp = lo | hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pix <= '0;
        else if (en[2])  pix <= pix_n;
    end

endmodule

// File: rtl/bicubic_h_filter.sv
// bicubic_h_filter
//   Horizontal bicubic pass: delays each 4-pixel window WGT_LAT cycles to
//   meet its weights, then runs CH parallel 3-stage MACs. Latency
//   WGT_LAT+3, one window per clock, no backpressure.
//   Optional macro BICUBIC_HFILT_SATCNT_EN enables the saturating
//   clamp-event counter on sat_cnt (tied to 0 otherwise).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid, in_last   window valid / end of output line
//   p0..p3              taps x0..x3, CH channels of DW, channel 0 in LSBs
//   w0..w3              weights for the window presented WGT_LAT cycles ago
//   out_valid, out_last output beat valid / aligned in_last
//   out_pix             filtered pixel, holds while out_valid is low
//   sat_cnt             beats with any channel clamped
module bicubic_h_filter #(
    parameter int DW      = 8,
    parameter int CH      = 3,
    parameter int WW      = bicubic_h_filter_pkg::WW,
    parameter int FRAC    = bicubic_h_filter_pkg::FRAC,
    parameter int WGT_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [CH*DW-1:0] p0,
    input  logic [CH*DW-1:0] p1,
    input  logic [CH*DW-1:0] p2,
    input  logic [CH*DW-1:0] p3,
    input  logic [WW-1:0]    w0,
    input  logic [WW-1:0]    w1,
    input  logic [WW-1:0]    w2,
    input  logic [WW-1:0]    w3,
    output logic             out_valid,
    output logic             out_last,
    output logic [CH*DW-1:0] out_pix,
    output logic [15:0]      sat_cnt
);
    localparam int PXW = CH * DW;

    typedef struct packed {
        logic                vld;
        logic                last;
        logic [3:0][PXW-1:0] p;
    } win_t;

    win_t win_in, win_al;
    assign win_in = '{vld: in_valid, last: in_last, p: {p3, p2, p1, p0}};

    // Alignment delay line so the window meets its late weights
    generate
        if (WGT_LAT == 0) begin : g_nodly
            assign win_al = win_in;
        end else begin : g_dly
            win_t [WGT_LAT-1:0] dly;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly <= '0;
                end else begin
                    dly[0] <= win_in;
                    for (int i = 1; i < WGT_LAT; i++) dly[i] <= dly[i-1];
                end
            end
            assign win_al = dly[WGT_LAT-1];
        end
    endgenerate

    // vld_pipe[k]/last_pipe[k]: beat has passed MAC stage k
    logic [3:1] vld_pipe, last_pipe;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[2:1], win_al.vld};
            last_pipe <= {last_pipe[2:1], win_al.last};
        end
    end

    logic [CH-1:0][DW-1:0] pix_ch;
    logic [CH-1:0]         clamp;

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            bicubic_tap_mac #(.DW(DW), .WW(WW), .FRAC(FRAC)) u_mac (
                .clk   (clk),
                .rst_n (rst_n),
                .en    ({vld_pipe[2], vld_pipe[1], win_al.vld}),
                .p0    (win_al.p[0][c*DW +: DW]),
                .p1    (win_al.p[1][c*DW +: DW]),
                .p2    (win_al.p[2][c*DW +: DW]),
                .p3    (win_al.p[3][c*DW +: DW]),
                .w0    (w0),
                .w1    (w1),
                .w2    (w2),
                .w3    (w3),
                .pix   (pix_ch[c]),
                .clamp (clamp[c])
            );
        end
    endgenerate

    assign out_valid = vld_pipe[3];
    assign out_last  = last_pipe[3];
    assign out_pix   = pix_ch;

`ifdef BICUBIC_HFILT_SATCNT_EN
    // Counted on the same edge that launches the beat, so sat_cnt already
    // includes the beat currently on out_valid.
    logic [15:0] sat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_q <= '0;
        else if (vld_pipe[2] && (|clamp) && (sat_q != 16'hFFFF))
            sat_q <= sat_q + 16'd1;
    end
    assign sat_cnt = sat_q;
`else
    logic unused_clamp;
    assign unused_clamp = ^clamp;
    assign sat_cnt      = '0;
`endif

endmodule

// File: tb/tb_bicubic_h_filter.sv
module tb_bicubic_h_filter;
    localparam int L   = 4;
    localparam int HSZ = 256;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0, in_last = 0;
    logic [23:0] p0 = 0, p1 = 0, p2 = 0, p3 = 0;
    logic [8:0]  w0 = 0, w1 = 0, w2 = 0, w3 = 0;
    logic        out_valid, out_last;
    logic [23:0] out_pix;
    logic [15:0] sat_cnt;

    bicubic_h_filter #(.DW(8), .CH(3), .WW(9), .FRAC(8), .WGT_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3),
        .out_valid(out_valid), .out_last(out_last), .out_pix(out_pix),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                v;
        bit                last;
        int                tag;
        logic [3:0][23:0]  p;
        logic [3:0][8:0]   w;
    } win_t;

    typedef struct {
        int          due;
        logic [23:0] pix;
        bit          last;
        bit          clp;
    } exp_t;

    win_t  hist [HSZ];
    exp_t  q [$];
    int    cyc = 0;
    int    n_chk = 0, n_fail = 0;
    logic [23:0] held = 0;
    int    sat_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer filter, floor division, clamp per channel.
    // Returns {clamped_any, pixel}.
    function automatic logic [24:0] model(input win_t x);
        logic [23:0] pix;
        bit clp;
        int a, r, v;
        pix = 0; clp = 0;
        for (int c = 0; c < 3; c++) begin
            a = int'(x.w[1]) * int'(x.p[1][c*8 +: 8]) + int'(x.w[2]) * int'(x.p[2][c*8 +: 8])
              - int'(x.w[0]) * int'(x.p[0][c*8 +: 8]) - int'(x.w[3]) * int'(x.p[3][c*8 +: 8]);
            r = a + 128;
            v = (r >= 0) ? r / 256 : -((-r + 255) / 256);
            if (v < 0) begin v = 0; clp = 1; end
            else if (v > 255) begin v = 255; clp = 1; end
            pix[c*8 +: 8] = v[7:0];
        end
        return {clp, pix};
    endfunction

    function automatic win_t mk(input int a0, a1, a2, a3, input logic [23:0] q0, q1, q2, q3);
        win_t x;
        x.v = 1; x.last = 0; x.tag = 0;
        x.w[0] = 9'(a0); x.w[1] = 9'(a1); x.w[2] = 9'(a2); x.w[3] = 9'(a3);
        x.p[0] = q0; x.p[1] = q1; x.p[2] = q2; x.p[3] = q3;
        return x;
    endfunction

    function automatic win_t rnd_win(input bit v, input bit last);
        win_t x;
        x.v = v; x.last = last; x.tag = 0;
        for (int i = 0; i < 4; i++) begin
            x.p[i] = 24'($urandom);
            x.w[i] = 9'($urandom_range(0, 511));
        end
        return x;
    endfunction

    // One cycle: present window x, and the weights of the window presented
    // L cycles earlier (random junk if there was none).
    task automatic drive(input win_t x);
        int n, k;
        logic [24:0] m;
        @(posedge clk); #1;
        n = cyc;
        x.tag = n;
        hist[n % HSZ] = x;
        in_valid = x.v; in_last = x.last;
        p0 = x.p[0]; p1 = x.p[1]; p2 = x.p[2]; p3 = x.p[3];
        k = (n - L) % HSZ;
        if (n >= L && hist[k].v && hist[k].tag == n - L) begin
            w0 = hist[k].w[0]; w1 = hist[k].w[1]; w2 = hist[k].w[2]; w3 = hist[k].w[3];
        end else begin
            w0 = 9'($urandom); w1 = 9'($urandom); w2 = 9'($urandom); w3 = 9'($urandom);
        end
        if (x.v) begin
            m = model(x);
            q.push_back('{due: n + L + 3, pix: m[23:0], last: x.last, clp: m[24]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(rnd_win(0, $urandom_range(0, 1) == 1));
    endtask

    task automatic pin(input string name, input win_t x, input logic [23:0] lit);
        logic [24:0] m;
        m = model(x);
        chk(name, {8'd0, m[23:0]}, {8'd0, lit});
    endtask

    // Every cycle outside reset: out_valid exactly when a beat is due,
    // data/last/sat match the model, out_pix holds between beats.
    always @(negedge clk) begin
        if (rst_n) begin
            bit due;
            exp_t e;
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                chk("missed_beat", 0, 1);
            end
            due = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", {31'd0, out_valid}, {31'd0, due});
            if (due) begin
                e = q.pop_front();
                if (out_valid) begin
                    chk("out_pix", {8'd0, out_pix}, {8'd0, e.pix});
                    chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                    held = e.pix;
                    if (e.clp && sat_exp < 65535) sat_exp++;
                end
            end else if (!out_valid) begin
                chk("out_pix_hold", {8'd0, out_pix}, {8'd0, held});
            end
`ifdef BICUBIC_HFILT_SATCNT_EN
            chk("sat_cnt", {16'd0, sat_cnt}, sat_exp);
`else
            chk("sat_cnt", {16'd0, sat_cnt}, 0);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        win_t x;
        for (int i = 0; i < HSZ; i++) hist[i].v = 0;

        // Reset state
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_last",  {31'd0, out_last}, 0);
        chk("rst_out_pix",   {8'd0, out_pix}, 0);
        chk("rst_sat_cnt",   {16'd0, sat_cnt}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        idle(4);

        // Identity: single beat, exact latency checked by the compare process
        x = mk(0, 256, 0, 0, 24'h0, 24'h1E140A, 24'h0, 24'h0);
        pin("pin_identity", x, 24'h1E140A);
        drive(x); idle(10);

        // Flat, step edge, clamp low/high (all with the half-phase kernel)
        x = mk(16, 144, 144, 16, 24'h646464, 24'h646464, 24'h646464, 24'h646464);
        pin("pin_flat", x, 24'h646464);
        drive(x);
        x = mk(16, 144, 144, 16, 24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF);
        pin("pin_step", x, 24'h808080);
        drive(x);
        x = mk(16, 144, 144, 16, 24'hFFFFFF, 24'h0, 24'h0, 24'hFFFFFF);
        pin("pin_clamp_lo", x, 24'h000000);
        drive(x);
        x = mk(16, 144, 144, 16, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0);
        pin("pin_clamp_hi", x, 24'hFFFFFF);
        drive(x);
        idle(10);

        // Back-to-back burst, last on the 8th
        for (int i = 0; i < 8; i++) drive(rnd_win(1, i == 7));
        idle(10);
        // Same with single-cycle bubbles
        for (int i = 0; i < 8; i++) begin
            drive(rnd_win(1, i == 7));
            if (i != 7) drive(rnd_win(0, 1));
        end
        idle(10);

        // Random traffic
        for (int i = 0; i < 400; i++)
            drive(rnd_win($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0));
        idle(10);

        // Make sure out_pix is nonzero before the mid-burst reset
        drive(mk(0, 256, 0, 0, 24'h0, 24'h55AA33, 24'h0, 24'h0));
        drive(mk(16, 144, 144, 16, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0));
        idle(10);

        // Reset with 3 windows in flight
        for (int i = 0; i < 3; i++) drive(rnd_win(1, i == 2));
        @(posedge clk); #1;
        rst_n = 0; in_valid = 0; in_last = 0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_out_pix",   {8'd0, out_pix}, 0);
        chk("midrst_sat_cnt",   {16'd0, sat_cnt}, 0);
        q.delete();
        held = 0; sat_exp = 0;
        for (int i = 0; i < HSZ; i++) hist[i].v = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        idle(12);

        // Traffic after reset
        for (int i = 0; i < 20; i++) drive(rnd_win(1, i == 19));
        idle(12);

        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
